// File: rtl/ps2_pkg.sv
// Shared types, timing helpers and parity for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    REQ      = 3'd2,
    SEND     = 3'd3,
    ACK      = 3'd4,
    WAITIDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned CNT_W      = 20;
  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned inhibit_cycles(input int unsigned clk_hz,
                                                 input int unsigned inhibit_us);
    return (clk_hz / 1_000_000) * inhibit_us;
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned timeout_ms);
    return (clk_hz / 1000) * timeout_ms;
  endfunction

  localparam int unsigned INHIBIT_CYC = inhibit_cycles(25_000_000, 120);
  localparam int unsigned TIMEOUT_CYC = timeout_cycles(25_000_000, 20);

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronisers for the PS/2 CLOCK and DATA pins plus a CLOCK falling-edge strobe.
module ps2_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ps_clock_i,
  input  logic ps_data_i,
  output logic sync_clk_o,
  output logic sync_data_o,
  output logic clk_fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] data_ff_q;
  logic       clk_prev_q;

  // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_ff_q   <= 2'b11;
      data_ff_q  <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], ps_clock_i};
      data_ff_q  <= {data_ff_q[0], ps_data_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign sync_clk_o  = clk_ff_q[1];
  assign sync_data_o = data_ff_q[1];
  assign clk_fall_o  = ({clk_prev_q, clk_ff_q[1]} == 2'b10);

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks out one command byte,
// checks the device ACK and aborts on a missing device edge.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | lines released, waiting for start
//   INHIBIT  | host holds CLOCK low for the inhibit time
//   REQ      | DATA pulled low (start bit), CLOCK still held one cycle
//   SEND     | drive frame bit on each device CLOCK falling edge
//   ACK      | sample device ACK on the next falling edge
//   WAITIDLE | wait for CLOCK and DATA both high before reporting done
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_MS = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps_clock,
  input  logic       ps_data,
  output logic       ps_clock_oe,
  output logic       ps_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(inhibit_cycles(CLK_HZ, INHIBIT_US) - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(timeout_cycles(CLK_HZ, TIMEOUT_MS));
  localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

  ps2_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]  frame_q, frame_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic sync_clk;
  logic sync_data;
  logic clk_fall;
  logic timed;

  ps2_sync u_sync (
    .clk_i       (clock),
    .rst_n_i     (reset_n),
    .ps_clock_i  (ps_clock),
    .ps_data_i   (ps_data),
    .sync_clk_o  (sync_clk),
    .sync_data_o (sync_data),
    .clk_fall_o  (clk_fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign timed = (state_q == REQ) || (state_q == SEND) ||
                 (state_q == ACK) || (state_q == WAITIDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    // Watchdog restarts on every device falling edge.
    if (timed) begin
      cnt_d = clk_fall ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A start coinciding with the done/error pulse belongs to the finished transfer.
        if (start && !done_q && !error_q) begin
          frame_d   = {1'b1, odd_parity(data), data};
          state_d   = INHIBIT;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          cnt_d     = '0;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        bitcnt_d = '0;
        state_d  = SEND;
      end
      SEND: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!sync_data) begin
            state_d = WAITIDLE;
          end else begin
            error_d   = 1'b1;
            busy_d    = 1'b0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      WAITIDLE: begin
        if (sync_clk && sync_data) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase

    if (timed && (cnt_q > TO_LIMIT)) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b1;
      cnt_d     = '0;
    end
  end

  assign ps_clock_oe = clk_oe_q;
  assign ps_data_oe  = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
